fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch and program-counter stage of the 16-bit CPU. It owns the PC, the instruction register and the N/Z condition flags, drives the instruction-memory address, and presents the current instruction and its 5-bit opcode to the opcode decoder. It consumes the decoder's control outputs (`fetch`, `busy`, `pc_enable`, `BrSrc`, `BrCond`, `NZ`) to resolve branches, update flags and stall across load/store.

## Interface
- `RESET_PC`, default 16'h0000: PC value after reset. Bit 0 must be 0.
- `NOP_OPCODE`, default 5'b11111: opcode driven while no valid instruction is present. It decodes to the decoder's default, side-effect-free case.

Clock and reset are `clk` and `reset`: reset is asynchronous and active-high.

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `fetch`  in  1  decoder fetch strobe; the instruction may retire when high
- `busy`  in  1  decoder is executing a multi-cycle ld/st; the memory port belongs to data
- `pc_enable`  in  1  current instruction is a jump
- `BrSrc`  in  1  1: PC-relative imm11 target; 0: register target
- `BrCond`  in  2  00 always, 01 if Z, 10 if N, 11 never
- `NZ`  in  1  update flags from `alu_result` when the instruction retires
- `alu_result`  in  16  ALU output of the current instruction
- `rx_data`  in  16  register-file value of Rx, used as the jr-family target
- `mem_rdata`  in  16  synchronous instruction-memory read data, 1-cycle latency
- `imem_addr`  out  16  instruction-memory address
- `instr`  out  16  current instruction word
- `opcode`  out  5  `instr[4:0]`, or `NOP_OPCODE` when invalid
- `instr_valid`  out  1  `instr` holds the instruction at `pc`
- `pc`  out  16  address of the current instruction
- `pc_plus2`  out  16  `pc + 2`, modulo 2^16; consumed by the writeback mux
- `flag_n`, `flag_z`  out  1 each  registered condition flags
- `br_taken`  out  1  combinational: a jump is taken this cycle

## Operation
- States: BOOT, RUN, STALL, REFILL.
- **retire** = state RUN && `fetch` && !`busy`.
- **taken**: `pc_enable` && condition, where the condition is 1 for 00, `flag_z` for 01, `flag_n` for 10, and 0 for 11. `br_taken` = taken && retire.
- **next_pc**:
  - not taken: `pc_plus2`.
  - taken with `BrSrc`=1: `pc_plus2 + {sext(instr[15:5]) << 1}`, truncated to 16 bits.
  - taken with `BrSrc`=0: `{rx_data[15:1], 1'b0}`.
- **BOOT** (entered on reset): `imem_addr`=`pc`, `instr_valid`=0. Next state is RUN.
- **RUN**:
  - `instr`=`mem_rdata` and `instr_valid`=1.
  - `imem_addr` = retire ? next_pc : `pc`.
  - On retire: `pc`<=next_pc.
  - If `busy`=1: `ir`<=`mem_rdata`, `pc` holds, go to STALL.
- **STALL**:
  - `instr`=`ir`, `instr_valid`=1, `imem_addr`=`pc`.
  - Stay while `busy`=1.
  - When `busy`=0: `pc`<=`pc_plus2`, `imem_addr`=`pc_plus2`, go to REFILL.
- **REFILL**: `instr_valid`=0, `imem_addr`=`pc`. Next state is RUN.
- **Flags**: on retire with `NZ`=1, `flag_z`<=(`alu_result`==0) and `flag_n`<=`alu_result[15]`. Otherwise the flags hold.
- When `instr_valid`=0, `opcode`=`NOP_OPCODE`.

## Timing
- Reset values: `pc`=`RESET_PC`, `ir`=0, `flag_n`=`flag_z`=0, state=BOOT, `instr_valid`=0, `opcode`=`NOP_OPCODE`, `imem_addr`=`RESET_PC`, `br_taken`=0.
- The first valid instruction appears 1 cycle after reset deasserts.
- Throughput is 1 instruction per cycle in RUN, including taken jumps. There is no branch bubble because `imem_addr` is driven combinationally from next_pc.
- A ld/st costs the decoder's busy cycles plus 1 REFILL bubble.
- A flag update and a conditional jump in the same cycle: the jump uses the old, registered flags.
- PC wraps: 16'hFFFE + 2 = 16'h0000. This applies equally to relative targets.
- `fetch`=0 in RUN: no retire, `pc` and flags hold, `imem_addr`=`pc`.
- Reset asserted mid-STALL or mid-REFILL returns immediately to BOOT with reset values.

## Structure
- Shared package `cpu_pkg` holds:
  - BrCond encodings (`BR_ALWAYS`, `BR_Z`, `BR_N`, `BR_NEVER`).
  - `NOP_OPCODE`.
  - Instruction field positions: opcode [4:0], Rx [7:5], imm8 [15:8], imm11 [15:5].
  - The fetch state enum.
- One combinational sub-module, `branch_resolver`, computes taken and next_pc.

## Test plan
- **Reset**: release reset with `RESET_PC`=0 -> `imem_addr`=0, then `instr_valid`=1 and `pc`=0 the next cycle; with `fetch`=1 and `busy`=0, `pc` steps 0, 2, 4.
- **Relative jump**: `pc`=16'h0010, `instr[15:5]`=11'h7FE (-2), `pc_enable`=1, `BrSrc`=1, `BrCond`=00 -> `br_taken`=1, next `pc`=16'h000E.
- **Conditional on Z**: cmp with `alu_result`=0 and `NZ`=1 retires, then jz -> taken; with `alu_result`=16'h8000 -> `flag_n`=1, `flag_z`=0, jz not taken and jn taken.
- **Register jump**: jr with `rx_data`=16'h1235 -> `pc`=16'h1234; `BrCond`=11 -> not taken, `pc`=`pc_plus2`.
- **Load stall**: `busy` high for 2 cycles at `pc`=16'h0020 -> `pc` holds, `instr` stable from `ir` while `mem_rdata` changes; then 1 REFILL cycle with `opcode`=5'b11111; RUN resumes at 16'h0022.
- **Wrap and reset**: `pc`=16'hFFFE retires -> `pc`=0; assert reset during STALL -> BOOT, flags 0, `pc`=`RESET_PC` in the same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: branch-condition encodings,
// instruction field positions, the default NOP opcode and the fetch FSM states.
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_ALWAYS = 2'b00,
        BR_Z      = 2'b01,
        BR_N      = 2'b10,
        BR_NEVER  = 2'b11
    } br_cond_e;

    typedef enum logic [1:0] {
        FS_BOOT,
        FS_RUN,
        FS_STALL,
        FS_REFILL
    } fetch_state_e;

    localparam logic [4:0] NOP_OPCODE = 5'b11111;

    localparam int unsigned OPC_LSB   = 0;
    localparam int unsigned OPC_MSB   = 4;
    localparam int unsigned RX_LSB    = 5;
    localparam int unsigned RX_MSB    = 7;
    localparam int unsigned IMM8_LSB  = 8;
    localparam int unsigned IMM8_MSB  = 15;
    localparam int unsigned IMM11_LSB = 5;
    localparam int unsigned IMM11_MSB = 15;

    // imm11 counts halfwords; the byte offset is the sign-extended field times two.
    function automatic logic [15:0] imm11_offset(input logic [10:0] imm11);
        return {{4{imm11[10]}}, imm11, 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its neighbours: decoder controls,
// ALU/register operands, instruction-memory port and the fetch-stage outputs.
interface fetch_unit_if;

    logic        fetch;
    logic        busy;
    logic        pc_enable;
    logic        BrSrc;
    logic [1:0]  BrCond;
    logic        NZ;
    logic [15:0] alu_result;
    logic [15:0] rx_data;
    logic [15:0] mem_rdata;

    logic [15:0] imem_addr;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        flag_n;
    logic        flag_z;
    logic        br_taken;

    modport master (
        input  fetch, busy, pc_enable, BrSrc, BrCond, NZ,
               alu_result, rx_data, mem_rdata,
        output imem_addr, instr, opcode, instr_valid, pc, pc_plus2,
               flag_n, flag_z, br_taken
    );

    modport slave (
        output fetch, busy, pc_enable, BrSrc, BrCond, NZ,
               alu_result, rx_data, mem_rdata,
        input  imem_addr, instr, opcode, instr_valid, pc, pc_plus2,
               flag_n, flag_z, br_taken
    );

endinterface

// File: rtl/branch_resolver.sv
// Combinational branch resolution: evaluates the jump condition against the
// registered flags and selects the next PC (sequential, PC-relative or register).
module branch_resolver (
    input  logic [15:0] pc_plus2,
    input  logic [10:0] imm11,
    input  logic [15:0] rx_data,
    input  logic        pc_enable,
    input  logic        br_src,
    input  logic [1:0]  br_cond,
    input  logic        flag_n,
    input  logic        flag_z,
    output logic        taken,
    output logic [15:0] next_pc
);
    import cpu_pkg::*;

    logic cond_met;

    always_comb begin
        cond_met = 1'b0;
        case (br_cond_e'(br_cond))
            BR_ALWAYS: cond_met = 1'b1;
            BR_Z:      cond_met = flag_z;
            BR_N:      cond_met = flag_n;
            BR_NEVER:  cond_met = 1'b0;
            default:   cond_met = 1'b0;
        endcase

        taken   = pc_enable && cond_met;
        next_pc = pc_plus2;
        if (taken) begin
            // Register targets are forced halfword-aligned.
            next_pc = br_src ? (pc_plus2 + imm11_offset(imm11))
                             : (rx_data & 16'hFFFE);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: owns PC, IR and N/Z flags, drives the
// instruction-memory address and stalls across decoder-driven ld/st.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [4:0]  NOP_OPCODE = cpu_pkg::NOP_OPCODE
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    import cpu_pkg::*;

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  ir_q, ir_d;
    logic         flag_n_q, flag_n_d;
    logic         flag_z_q, flag_z_d;

    logic [15:0]  pc_plus2;
    logic [15:0]  next_pc;
    logic [15:0]  imem_addr;
    logic [15:0]  instr;
    logic         instr_valid;
    logic         retire;
    logic         taken;

    assign pc_plus2 = pc_q + 16'd2;
    assign retire   = (state_q == FS_RUN) && bus.fetch && !bus.busy;

    branch_resolver u_branch_resolver (
        .pc_plus2 (pc_plus2),
        .imm11    (instr[IMM11_MSB:IMM11_LSB]),
        .rx_data  (bus.rx_data),
        .pc_enable(bus.pc_enable),
        .br_src   (bus.BrSrc),
        .br_cond  (bus.BrCond),
        .flag_n   (flag_n_q),
        .flag_z   (flag_z_q),
        .taken    (taken),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FS_BOOT;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        flag_n_d    = flag_n_q;
        flag_z_d    = flag_z_q;
        imem_addr   = pc_q;
        instr       = bus.mem_rdata;
        instr_valid = 1'b0;

        case (state_q)
            FS_BOOT: begin
                state_d = FS_RUN;
            end

            FS_RUN: begin
                instr_valid = 1'b1;
                // Addressing next_pc directly avoids a bubble on taken jumps.
                if (retire) begin
                    imem_addr = next_pc;
                    pc_d      = next_pc;
                    if (bus.NZ) begin
                        flag_z_d = (bus.alu_result == 16'h0000);
                        flag_n_d = bus.alu_result[15];
                    end
                end
                if (bus.busy) begin
                    ir_d    = bus.mem_rdata;
                    state_d = FS_STALL;
                end
            end

            FS_STALL: begin
                instr       = ir_q;
                instr_valid = 1'b1;
                if (!bus.busy) begin
                    pc_d      = pc_plus2;
                    imem_addr = pc_plus2;
                    state_d   = FS_REFILL;
                end
            end

            FS_REFILL: begin
                state_d = FS_RUN;
            end

            default: begin
                state_d = FS_BOOT;
            end
        endcase
    end

    assign bus.imem_addr   = imem_addr;
    assign bus.instr       = instr;
    assign bus.instr_valid = instr_valid;
    assign bus.opcode      = instr_valid ? instr[OPC_MSB:OPC_LSB] : NOP_OPCODE;
    assign bus.pc          = pc_q;
    assign bus.pc_plus2    = pc_plus2;
    assign bus.flag_n      = flag_n_q;
    assign bus.flag_z      = flag_z_q;
    assign bus.br_taken    = taken && retire;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic, all compared against a phase-level reference model of the stage.
module tb_fetch_unit;

    localparam int PH_BOOT   = 0;
    localparam int PH_RUN    = 1;
    localparam int PH_STALL  = 2;
    localparam int PH_REFILL = 3;
    localparam logic [4:0] NOP = 5'b11111;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(16'h0000), .NOP_OPCODE(NOP)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] imem_ovr [logic [15:0]];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (imem_ovr.exists(a)) return imem_ovr[a];
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Data traffic owns the port while busy: return data that never matches the instruction.
    always @(posedge clk)
        bus.mem_rdata <= bus.busy ? (~mem_word(bus.imem_addr) ^ {8'h00, 8'($urandom)})
                                  : mem_word(bus.imem_addr);

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    // Reference model state and per-cycle expectations
    int          m_phase, n_phase;
    logic [15:0] m_pc, n_pc;
    logic        m_fn, m_fz, n_fn, n_fz;
    logic        d_fetch, d_busy, d_pe, d_bs, d_nz;
    logic [1:0]  d_cond;
    logic [15:0] d_alu, d_rx;
    logic [15:0] exp_addr, exp_instr, exp_pc, exp_pc2;
    logic [4:0]  exp_opc;
    logic        exp_valid, exp_fn, exp_fz, exp_br;

    function automatic void model_reset();
        m_phase = PH_BOOT; m_pc = 16'h0000; m_fn = 1'b0; m_fz = 1'b0;
        n_phase = m_phase; n_pc = m_pc; n_fn = m_fn; n_fz = m_fz;
    endfunction

    function automatic void model_commit();
        m_phase = n_phase; m_pc = n_pc; m_fn = n_fn; m_fz = n_fz;
    endfunction

    function automatic void eval_model();
        logic [15:0] w;
        logic        cond, ret, tk;
        int          off, tgt;
        w = mem_word(m_pc);
        n_phase = m_phase; n_pc = m_pc; n_fn = m_fn; n_fz = m_fz;
        exp_pc = m_pc;
        exp_pc2 = 16'((int'(m_pc) + 2) % 65536);
        exp_fn = m_fn; exp_fz = m_fz; exp_br = 1'b0;
        exp_instr = w; exp_valid = 1'b0; exp_addr = m_pc;
        case (m_phase)
            PH_BOOT: n_phase = PH_RUN;
            PH_RUN: begin
                exp_valid = 1'b1;
                ret = d_fetch && !d_busy;
                case (d_cond)
                    2'b00:   cond = 1'b1;
                    2'b01:   cond = m_fz;
                    2'b10:   cond = m_fn;
                    default: cond = 1'b0;
                endcase
                tk = d_pe && cond;
                if (!tk) tgt = (int'(m_pc) + 2) % 65536;
                else if (d_bs) begin
                    off = int'(w[15:5]);
                    if (off >= 1024) off -= 2048;
                    tgt = (int'(m_pc) + 2 + 2 * off + 65536) % 65536;
                end else tgt = int'(d_rx) - (int'(d_rx) % 2);
                exp_br = tk && ret;
                exp_addr = ret ? 16'(tgt) : m_pc;
                if (ret) begin
                    n_pc = 16'(tgt);
                    if (d_nz) begin
                        n_fz = (d_alu == 16'h0000);
                        n_fn = (d_alu >= 16'h8000);
                    end
                end
                if (d_busy) n_phase = PH_STALL;
            end
            PH_STALL: begin
                exp_valid = 1'b1;
                if (!d_busy) begin
                    exp_addr = exp_pc2; n_pc = exp_pc2; n_phase = PH_REFILL;
                end
            end
            default: n_phase = PH_RUN;
        endcase
        exp_opc = exp_valid ? w[4:0] : NOP;
    endfunction

    task automatic set_inputs(input logic f, input logic b, input logic pe, input logic bs,
                              input logic [1:0] bc, input logic nz,
                              input logic [15:0] alu, input logic [15:0] rx);
        bus.fetch = f; bus.busy = b; bus.pc_enable = pe; bus.BrSrc = bs;
        bus.BrCond = bc; bus.NZ = nz; bus.alu_result = alu; bus.rx_data = rx;
        d_fetch = f; d_busy = b; d_pe = pe; d_bs = bs; d_cond = bc; d_nz = nz;
        d_alu = alu; d_rx = rx;
    endtask

    task automatic drive_eval(input logic f, input logic b, input logic pe, input logic bs,
                              input logic [1:0] bc, input logic nz,
                              input logic [15:0] alu, input logic [15:0] rx);
        set_inputs(f, b, pe, bs, bc, nz, alu, rx);
        #1;
        eval_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic step(input logic f, input logic b, input logic pe, input logic bs,
                        input logic [1:0] bc, input logic nz,
                        input logic [15:0] alu, input logic [15:0] rx);
        advance();
        drive_eval(f, b, pe, bs, bc, nz, alu, rx);
    endtask

    task automatic jump_to(input logic [15:0] a);
        step(1, 0, 1, 0, 2'b00, 0, 16'h0000, a);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_inputs(0, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (bus.imem_addr !== 16'h0000) $display("FAIL rst_addr got=%h exp=%h", bus.imem_addr, 16'h0000); else n_pass++;
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); else n_pass++;
        n_checks++; if (bus.opcode !== NOP) $display("FAIL rst_opcode got=%b exp=%b", bus.opcode, NOP); else n_pass++;
        n_checks++; if (bus.pc !== 16'h0000) $display("FAIL rst_pc got=%h exp=0000", bus.pc); else n_pass++;
        n_checks++; if ({bus.flag_n, bus.flag_z, bus.br_taken} !== 3'b000) $display("FAIL rst_flags got=%b exp=000", {bus.flag_n, bus.flag_z, bus.br_taken}); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        drive_eval(1, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        n_checks++; if (bus.imem_addr !== 16'h0000) $display("FAIL boot_addr got=%h exp=0000", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL boot_valid got=%b exp=0", bus.instr_valid); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
            n_checks++; if (bus.instr_valid !== 1'b1) $display("FAIL seq_valid got=%b exp=1", bus.instr_valid); else n_pass++;
            n_checks++; if (bus.pc !== 16'(2 * i)) $display("FAIL seq_pc got=%h exp=%h", bus.pc, 16'(2 * i)); else n_pass++;
            n_checks++; if (bus.instr !== exp_instr) $display("FAIL seq_instr got=%h exp=%h", bus.instr, exp_instr); else n_pass++;
        end
    endtask

    task automatic test_rel_jump();
        imem_ovr[16'h0010] = {11'h7FE, 5'b01010};
        jump_to(16'h0010);
        step(1, 0, 1, 1, 2'b00, 0, 16'h0000, 16'hBEEF);
        n_checks++; if (bus.pc !== 16'h0010) $display("FAIL rel_pc got=%h exp=0010", bus.pc); else n_pass++;
        n_checks++; if (bus.br_taken !== 1'b1) $display("FAIL rel_taken got=%b exp=1", bus.br_taken); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h000E) $display("FAIL rel_addr got=%h exp=000E", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.opcode !== 5'b01010) $display("FAIL rel_opcode got=%b exp=01010", bus.opcode); else n_pass++;
        step(1, 0, 0, 0, 2'b00, 1, 16'h0000, 16'h0000);
        n_checks++; if (bus.pc !== 16'h000E) $display("FAIL rel_pc_after got=%h exp=000E", bus.pc); else n_pass++;
    endtask

    task automatic test_cond_flags();
        step(1, 0, 1, 0, 2'b01, 0, 16'h0000, 16'h0100);
        n_checks++; if (bus.flag_z !== 1'b1) $display("FAIL cz_flag_z got=%b exp=1", bus.flag_z); else n_pass++;
        n_checks++; if (bus.br_taken !== 1'b1) $display("FAIL cz_jz_taken got=%b exp=1", bus.br_taken); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h0100) $display("FAIL cz_jz_addr got=%h exp=0100", bus.imem_addr); else n_pass++;
        step(1, 0, 0, 0, 2'b00, 1, 16'h8000, 16'h0000);
        step(1, 0, 1, 0, 2'b01, 0, 16'h0000, 16'h0200);
        n_checks++; if ({bus.flag_n, bus.flag_z} !== 2'b10) $display("FAIL cn_flags got=%b exp=10", {bus.flag_n, bus.flag_z}); else n_pass++;
        n_checks++; if (bus.br_taken !== 1'b0) $display("FAIL cn_jz_taken got=%b exp=0", bus.br_taken); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h0104) $display("FAIL cn_jz_addr got=%h exp=0104", bus.imem_addr); else n_pass++;
        step(1, 0, 1, 0, 2'b10, 0, 16'h0000, 16'h0301);
        n_checks++; if (bus.br_taken !== 1'b1) $display("FAIL cn_jn_taken got=%b exp=1", bus.br_taken); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h0300) $display("FAIL cn_jn_addr got=%h exp=0300", bus.imem_addr); else n_pass++;
        // Flag write and jz in one cycle: the jump must see the old Z=0.
        step(1, 0, 1, 0, 2'b01, 1, 16'h0000, 16'h0400);
        n_checks++; if (bus.br_taken !== 1'b0) $display("FAIL same_cycle_taken got=%b exp=0", bus.br_taken); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h0302) $display("FAIL same_cycle_addr got=%h exp=0302", bus.imem_addr); else n_pass++;
        step(1, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        n_checks++; if ({bus.flag_n, bus.flag_z} !== 2'b01) $display("FAIL same_cycle_flags got=%b exp=01", {bus.flag_n, bus.flag_z}); else n_pass++;
    endtask

    task automatic test_reg_jump();
        step(1, 0, 1, 0, 2'b00, 0, 16'h0000, 16'h1235);
        n_checks++; if (bus.imem_addr !== 16'h1234) $display("FAIL jr_addr got=%h exp=1234", bus.imem_addr); else n_pass++;
        step(1, 0, 1, 0, 2'b11, 0, 16'h0000, 16'h4000);
        n_checks++; if (bus.pc !== 16'h1234) $display("FAIL jr_pc got=%h exp=1234", bus.pc); else n_pass++;
        n_checks++; if (bus.br_taken !== 1'b0) $display("FAIL never_taken got=%b exp=0", bus.br_taken); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h1236) $display("FAIL never_addr got=%h exp=1236", bus.imem_addr); else n_pass++;
        step(1, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        n_checks++; if (bus.pc !== 16'h1236) $display("FAIL never_pc got=%h exp=1236", bus.pc); else n_pass++;
    endtask

    task automatic test_load_stall();
        logic [15:0] w20;
        w20 = mem_word(16'h0020);
        jump_to(16'h0020);
        step(1, 1, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        n_checks++; if (bus.imem_addr !== 16'h0020) $display("FAIL ld_run_addr got=%h exp=0020", bus.imem_addr); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step(1, (i == 0), 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
            n_checks++; if (bus.instr !== w20) $display("FAIL ld_stall_instr got=%h exp=%h", bus.instr, w20); else n_pass++;
            n_checks++; if (bus.pc !== 16'h0020) $display("FAIL ld_stall_pc got=%h exp=0020", bus.pc); else n_pass++;
            n_checks++; if (bus.instr_valid !== 1'b1) $display("FAIL ld_stall_valid got=%b exp=1", bus.instr_valid); else n_pass++;
        end
        n_checks++; if (bus.imem_addr !== 16'h0022) $display("FAIL ld_release_addr got=%h exp=0022", bus.imem_addr); else n_pass++;
        step(1, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL refill_valid got=%b exp=0", bus.instr_valid); else n_pass++;
        n_checks++; if (bus.opcode !== 5'b11111) $display("FAIL refill_opcode got=%b exp=11111", bus.opcode); else n_pass++;
        n_checks++; if (bus.pc !== 16'h0022) $display("FAIL refill_pc got=%h exp=0022", bus.pc); else n_pass++;
        step(1, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        n_checks++; if (bus.instr !== mem_word(16'h0022)) $display("FAIL resume_instr got=%h exp=%h", bus.instr, mem_word(16'h0022)); else n_pass++;
        n_checks++; if (bus.instr_valid !== 1'b1) $display("FAIL resume_valid got=%b exp=1", bus.instr_valid); else n_pass++;
    endtask

    task automatic test_wrap_reset();
        imem_ovr[16'hFFFE] = {11'h001, 5'b00011};
        jump_to(16'hFFFE);
        step(1, 0, 1, 1, 2'b00, 0, 16'h0000, 16'h0000);
        n_checks++; if (bus.imem_addr !== 16'h0002) $display("FAIL wrap_rel_addr got=%h exp=0002", bus.imem_addr); else n_pass++;
        jump_to(16'hFFFE);
        step(1, 0, 0, 0, 2'b00, 1, 16'h0000, 16'h0000);
        n_checks++; if (bus.pc_plus2 !== 16'h0000) $display("FAIL wrap_pc2 got=%h exp=0000", bus.pc_plus2); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h0000) $display("FAIL wrap_addr got=%h exp=0000", bus.imem_addr); else n_pass++;
        step(0, 1, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        n_checks++; if (bus.pc !== 16'h0000) $display("FAIL wrap_pc got=%h exp=0000", bus.pc); else n_pass++;
        n_checks++; if (bus.flag_z !== 1'b1) $display("FAIL wrap_flag_z got=%b exp=1", bus.flag_z); else n_pass++;
        step(0, 1, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        #2 reset = 1'b1;
        set_inputs(0, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        #1;
        n_checks++; if (bus.pc !== 16'h0000) $display("FAIL mid_rst_pc got=%h exp=0000", bus.pc); else n_pass++;
        n_checks++; if ({bus.flag_n, bus.flag_z} !== 2'b00) $display("FAIL mid_rst_flags got=%b exp=00", {bus.flag_n, bus.flag_z}); else n_pass++;
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", bus.instr_valid); else n_pass++;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_eval(1, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        n_checks++; if (bus.opcode !== NOP) $display("FAIL mid_rst_boot_opcode got=%b exp=%b", bus.opcode, NOP); else n_pass++;
        step(1, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
        n_checks++; if ({bus.instr_valid, bus.pc} !== {1'b1, 16'h0000}) $display("FAIL mid_rst_run got=%b/%h exp=1/0000", bus.instr_valid, bus.pc); else n_pass++;
    endtask

    task automatic test_random();
        logic        f, b, pe, bs, nz;
        logic [1:0]  bc;
        logic [15:0] alu, rx;
        for (int i = 0; i < 400; i++) begin
            advance();
            b = 1'b0;
            if (m_phase == PH_RUN) b = ($urandom_range(0, 7) == 0);
            else if (m_phase == PH_STALL) b = 1'($urandom_range(0, 1));
            f  = ($urandom_range(0, 3) != 0);
            pe = ($urandom_range(0, 2) == 0);
            bs = 1'($urandom);
            bc = 2'($urandom);
            nz = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       alu = 16'h0000;
                1:       alu = 16'h8000 | 16'($urandom);
                default: alu = 16'($urandom);
            endcase
            rx = 16'($urandom);
            drive_eval(f, b, pe, bs, bc, nz, alu, rx);
            n_checks++; if (bus.imem_addr !== exp_addr) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, bus.imem_addr, exp_addr); else n_pass++;
            n_checks++; if (bus.pc !== exp_pc) $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, bus.pc, exp_pc); else n_pass++;
            n_checks++; if (bus.pc_plus2 !== exp_pc2) $display("FAIL rnd_pc2 cyc=%0d got=%h exp=%h", i, bus.pc_plus2, exp_pc2); else n_pass++;
            n_checks++; if (bus.instr_valid !== exp_valid) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus.instr_valid, exp_valid); else n_pass++;
            n_checks++; if (bus.opcode !== exp_opc) $display("FAIL rnd_opcode cyc=%0d got=%b exp=%b", i, bus.opcode, exp_opc); else n_pass++;
            n_checks++; if ({bus.flag_n, bus.flag_z} !== {exp_fn, exp_fz}) $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {bus.flag_n, bus.flag_z}, {exp_fn, exp_fz}); else n_pass++;
            n_checks++; if (bus.br_taken !== exp_br) $display("FAIL rnd_taken cyc=%0d got=%b exp=%b", i, bus.br_taken, exp_br); else n_pass++;
            if (exp_valid) begin
                n_checks++; if (bus.instr !== exp_instr) $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, bus.instr, exp_instr); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rel_jump();
        test_cond_flags();
        test_reg_jump();
        test_load_stall();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
